// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: MD op codes, latency defaults,
// and the pending-result payload.
package md_sequencer_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [3:0] {
        MD_mult  = 4'd0,
        MD_multu = 4'd1,
        MD_div   = 4'd2,
        MD_divu  = 4'd3,
        MD_mfhi  = 4'd4,
        MD_mflo  = 4'd5,
        MD_mthi  = 4'd6,
        MD_mtlo  = 4'd7,
        MD_else  = 4'd15
    } md_op_e;

    // Result captured at start and committed when the busy count expires
    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } md_result_t;

    function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E-stage MD operand/control bundle and the HI/LO/stall results returned to the pipeline.
interface md_sequencer_if;
    import md_sequencer_pkg::*;

    md_op_e            E_MDOp;
    logic              E_start;
    logic [DATA_W-1:0] E_rs;
    logic [DATA_W-1:0] E_rt;
    logic              req;
    logic              D_isMDFT;
    logic [DATA_W-1:0] E_md_out;
    logic              busy;
    logic              stall_md;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;

    modport master (
        output E_MDOp, E_start, E_rs, E_rt, req, D_isMDFT,
        input  E_md_out, busy, stall_md, HI, LO
    );

    modport slave (
        input  E_MDOp, E_start, E_rs, E_rt, req, D_isMDFT,
        output E_md_out, busy, stall_md, HI, LO
    );

endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: computes the result at start, holds it for the fixed
// latency, then commits it to the architectural HI/LO registers.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    md_sequencer_if.slave  md
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    logic              state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              start_go, commit, mt_hi, mt_lo;
    logic              busy_q;
    logic [DATA_W-1:0] hi_q, lo_q;
    md_result_t        pend_q, res_c;

    logic [63:0]       a_sx, b_sx, prod_s, prod_u;
    logic [DATA_W-1:0] a_mag, b_mag, divisor_s, divisor_u;
    logic [DATA_W-1:0] q_mag, r_mag, q_u, r_u;

    // Products and quotients for every start op, selected by E_MDOp
    always_comb begin
        res_c     = '0;
        a_sx      = {{DATA_W{md.E_rs[DATA_W-1]}}, md.E_rs};
        b_sx      = {{DATA_W{md.E_rt[DATA_W-1]}}, md.E_rt};
        prod_s    = a_sx * b_sx;
        prod_u    = {32'd0, md.E_rs} * {32'd0, md.E_rt};
        a_mag     = neg_if(md.E_rs[DATA_W-1], md.E_rs);
        b_mag     = neg_if(md.E_rt[DATA_W-1], md.E_rt);
        // Substitute divisor keeps the divider defined; the write is suppressed anyway
        divisor_s = (b_mag == '0) ? DATA_W'(1) : b_mag;
        divisor_u = (md.E_rt == '0) ? DATA_W'(1) : md.E_rt;
        q_mag     = a_mag / divisor_s;
        r_mag     = a_mag % divisor_s;
        q_u       = md.E_rs / divisor_u;
        r_u       = md.E_rs % divisor_u;
        case (md.E_MDOp)
            MD_mult:  res_c = {1'b1, prod_s};
            MD_multu: res_c = {1'b1, prod_u};
            MD_div: begin
                res_c.we = (md.E_rt != '0);
                res_c.lo = neg_if(md.E_rs[DATA_W-1] ^ md.E_rt[DATA_W-1], q_mag);
                res_c.hi = neg_if(md.E_rs[DATA_W-1], r_mag);
            end
            MD_divu: begin
                res_c.we = (md.E_rt != '0);
                res_c.lo = q_u;
                res_c.hi = r_u;
            end
            default: res_c = '0;
        endcase
    end

    // State register with HI/LO and pending-result storage
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            pend_q <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            busy_q <= (state_next == ST_BUSY);
            if (start_go) pend_q <= res_c;
            if (commit && pend_q.we) begin
                hi_q <= pend_q.hi;
                lo_q <= pend_q.lo;
            end
            if (mt_hi) hi_q <= md.E_rs;
            if (mt_lo) lo_q <= md.E_rs;
        end
    end

    // Next state: a flushed E instruction never starts or writes
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start_go   = 1'b0;
        commit     = 1'b0;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        case (state)
            ST_IDLE: begin
                mt_hi = !md.req && (md.E_MDOp == MD_mthi);
                mt_lo = !md.req && (md.E_MDOp == MD_mtlo);
                if (md.E_start && !md.req) begin
                    start_go   = 1'b1;
                    state_next = ST_BUSY;
                    cnt_next   = ((md.E_MDOp == MD_mult) || (md.E_MDOp == MD_multu))
                               ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs: HI/LO read port and D-stage stall are combinational
    always_comb begin
        md.E_md_out = '0;
        md.stall_md = md.D_isMDFT && (md.E_start || busy_q);
        case (md.E_MDOp)
            MD_mfhi: md.E_md_out = hi_q;
            MD_mflo: md.E_md_out = lo_q;
            default: md.E_md_out = '0;
        endcase
    end

    assign md.busy = busy_q;
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: expected HI/LO pushed to a scoreboard at start,
// popped and compared when busy falls.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    md_sequencer_if mdi ();

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mdi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int n_exp, input bit probe);
        int   n;
        bit   stall_ok;
        exp_t e;
        mdi.E_MDOp   = op;
        mdi.E_rs     = rs;
        mdi.E_rt     = rt;
        mdi.E_start  = 1'b1;
        mdi.D_isMDFT = probe;
        sb.push_back('{hi: ehi, lo: elo});
        #1;
        if (probe) check("stall_start", 32'(mdi.stall_md), 32'd1);
        step();
        mdi.E_start = 1'b0;
        mdi.E_MDOp  = MD_else;
        #1;
        n = 0;
        stall_ok = 1'b1;
        while (mdi.busy && n < 40) begin
            n++;
            if (probe && !mdi.stall_md) stall_ok = 1'b0;
            step();
        end
        check("busy_cycles", 32'(n), 32'(n_exp));
        if (probe) begin
            check("stall_during_busy", 32'(stall_ok), 32'd1);
            check("stall_after_busy", 32'(mdi.stall_md), 32'd0);
        end
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("hi", mdi.HI, e.hi);
            check("lo", mdi.LO, e.lo);
            if (probe) begin
                mdi.E_MDOp = MD_mfhi;
                #1;
                check("mfhi_out", mdi.E_md_out, e.hi);
                mdi.D_isMDFT = 1'b0;
                mdi.E_MDOp   = MD_else;
            end
        end
    endtask

    task automatic mt(input md_op_e op, input logic [31:0] v, input logic rq);
        mdi.E_MDOp = op;
        mdi.E_rs   = v;
        mdi.req    = rq;
        step();
        mdi.E_MDOp = MD_else;
        mdi.req    = 1'b0;
        #1;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        clk          = 1'b0;
        reset        = 1'b1;
        mdi.E_MDOp   = MD_else;
        mdi.E_start  = 1'b0;
        mdi.E_rs     = '0;
        mdi.E_rt     = '0;
        mdi.req      = 1'b0;
        mdi.D_isMDFT = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_busy", 32'(mdi.busy), 32'd0);
        check("rst_hi", mdi.HI, 32'd0);
        check("rst_lo", mdi.LO, 32'd0);
        check("rst_md_out", mdi.E_md_out, 32'd0);

        run_op(MD_mult,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 1'b0);
        run_op(MD_multu, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0);
        run_op(MD_div,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
        run_op(MD_divu,  32'd7,         32'd2, 32'd1,         32'd3,         10, 1'b0);
        run_op(MD_mult,  32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 5, 1'b1);
        run_op(MD_div,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b0);

        // Flushed start must not launch
        mdi.E_MDOp  = MD_mult;
        mdi.E_rs    = 32'd3;
        mdi.E_rt    = 32'd4;
        mdi.E_start = 1'b1;
        mdi.req     = 1'b1;
        step();
        mdi.E_start = 1'b0;
        mdi.req     = 1'b0;
        mdi.E_MDOp  = MD_else;
        #1;
        check("req_start_busy", 32'(mdi.busy), 32'd0);
        step();
        check("req_start_busy2", 32'(mdi.busy), 32'd0);
        check("req_start_hi", mdi.HI, 32'd0);
        check("req_start_lo", mdi.LO, 32'h8000_0000);

        mt(MD_mthi, 32'h1234, 1'b1);
        check("mthi_req_hi", mdi.HI, 32'd0);
        mt(MD_mthi, 32'h1234, 1'b0);
        check("mthi_hi", mdi.HI, 32'h1234);
        mdi.E_MDOp = MD_mflo;
        #1;
        check("mflo_out", mdi.E_md_out, 32'h8000_0000);
        mdi.E_MDOp = MD_else;
        #1;
        check("else_out", mdi.E_md_out, 32'd0);

        // Reset during busy cycle 4 aborts the divide
        mdi.E_MDOp  = MD_divu;
        mdi.E_rs    = 32'd100;
        mdi.E_rt    = 32'd7;
        mdi.E_start = 1'b1;
        sb.push_back('{hi: 32'd2, lo: 32'd14});
        step();
        mdi.E_start = 1'b0;
        mdi.E_MDOp  = MD_else;
        for (int i = 1; i < 4; i++) step();
        check("pre_reset_busy", 32'(mdi.busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        void'(sb.pop_front());
        check("abort_busy", 32'(mdi.busy), 32'd0);
        check("abort_hi", mdi.HI, 32'd0);
        check("abort_lo", mdi.LO, 32'd0);
        for (int i = 0; i < 12; i++) step();
        check("abort_hi_late", mdi.HI, 32'd0);
        check("abort_lo_late", mdi.LO, 32'd0);

        // Divide by zero runs full latency and leaves HI/LO alone
        mt(MD_mthi, 32'hA, 1'b0);
        mt(MD_mtlo, 32'hB, 1'b0);
        check("preload_hi", mdi.HI, 32'hA);
        check("preload_lo", mdi.LO, 32'hB);
        run_op(MD_div, 32'd55, 32'd0, 32'hA, 32'hB, 10, 1'b0);
        run_op(MD_divu, 32'd55, 32'd0, 32'hA, 32'hB, 10, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
